// File: rtl/alu_port_arbiter.sv
// alu_port_arbiter
//   Shares one 32-bit ALU between two requesters. Each side has a valid/ready
//   request channel and a valid/ready response channel. One operation is in
//   flight at a time: IDLE (arbitrate/accept) -> EXEC (ALU evaluates the
//   registered op, result captured) -> RESP (result held until taken).
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   reqN_valid/ready          request handshake, N = 0/1
//   reqN_ctrl/rs/rt/sa        ALU opcode and operands
//   rspN_valid/ready          response handshake
//   rspN_rd/ovf               result and overflow flag
//   alu_rs/rt/ctrl/sa         registered op driven to the ALU
//   alu_rd/alu_overflow       ALU result inputs
//   busy                      high whenever the FSM is not IDLE
//   ovf_cnt                   saturating count of captured overflows
module alu_port_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [31:0]      req0_rs,
  input  logic [31:0]      req0_rt,
  input  logic [4:0]       req0_sa,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [31:0]      req1_rs,
  input  logic [31:0]      req1_rt,
  input  logic [4:0]       req1_sa,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_rd,
  output logic             rsp0_ovf,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_rd,
  output logic             rsp1_ovf,
  output logic [31:0]      alu_rs,
  output logic [31:0]      alu_rt,
  output logic [3:0]       alu_ctrl,
  output logic [4:0]       alu_sa,
  input  logic [31:0]      alu_rd,
  input  logic             alu_overflow,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_owner;
  logic             r_last_grant;
  logic [3:0]       r_ctrl;
  logic [31:0]      r_rs, r_rt, r_rd;
  logic [4:0]       r_sa;
  logic             r_ovf;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic             r_rsp0_valid, r_rsp1_valid, r_busy;

  logic w_idle, w_grant0, w_grant1, w_rsp_hs;

  // Readies are gated by rst so nothing looks accepted while reset is held.
  assign w_idle   = (r_state == S_IDLE) & ~rst;
  // req0 wins when alone, under fixed priority, or when req1 had the last grant.
  assign w_grant0 = w_idle & req0_valid & (~req1_valid | FIXED_PRIO | r_last_grant);
  assign w_grant1 = w_idle & req1_valid & ~w_grant0;
  assign w_rsp_hs = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Only the owner's port shows data; the idle port reads as zero.
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_rd    = r_rsp0_valid ? r_rd  : '0;
  assign rsp0_ovf   = r_rsp0_valid & r_ovf;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_rd    = r_rsp1_valid ? r_rd  : '0;
  assign rsp1_ovf   = r_rsp1_valid & r_ovf;

  assign alu_rs   = r_rs;
  assign alu_rt   = r_rt;
  assign alu_ctrl = r_ctrl;
  assign alu_sa   = r_sa;
  assign busy     = r_busy;
  assign ovf_cnt  = r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ctrl       <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_sa         <= '0;
      r_rd         <= '0;
      r_ovf        <= 1'b0;
      r_ovf_cnt    <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_ctrl       <= w_grant1 ? req1_ctrl : req0_ctrl;
            r_rs         <= w_grant1 ? req1_rs   : req0_rs;
            r_rt         <= w_grant1 ? req1_rt   : req0_rt;
            r_sa         <= w_grant1 ? req1_sa   : req0_sa;
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
            r_busy       <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rd  <= alu_rd;
          r_ovf <= alu_overflow;
          if (alu_overflow && (r_ovf_cnt != CNT_MAX))
            r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
